// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit, radix-2, fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_out,
  output logic             we_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [2:0]         r_f3;
  logic               r_a_neg;
  logic               r_b_neg;
  logic               r_bzero;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [4:0]         r_rd;

  // Operand signedness: op_a signed for MUL/MULH/MULHSU/DIV/REM, op_b for MUL/MULH/DIV/REM
  logic             w_sa;
  logic             w_sb;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;

  assign w_sa    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_sb    = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_a_neg = w_sa & op_a[WIDTH-1];
  assign w_b_neg = w_sb & op_b[WIDTH-1];
  assign w_a_abs = w_a_neg ? -op_a : op_a;
  assign w_b_abs = w_b_neg ? -op_b : op_b;

  // r_acc holds {partial product, multiplier} or {remainder, quotient/dividend}
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};

  always_comb begin
    w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    if (r_f3[2]) begin
      if (!w_diff[WIDTH])
        w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else
        w_acc_next = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  logic               w_sign_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  assign w_sign_diff = r_a_neg ^ r_b_neg;
  assign w_prod      = w_sign_diff ? -w_acc_next : w_acc_next;
  // A zero divisor yields an all-ones quotient regardless of the dividend sign
  assign w_quo       = r_bzero ? '1 :
                       (w_sign_diff ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0]);
  assign w_rem       = r_a_neg ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    case (r_f3)
      3'b000:         w_final = w_prod[WIDTH-1:0];
      3'b100, 3'b101: w_final = w_quo;
      3'b110, 3'b111: w_final = w_rem;
      default:        w_final = w_prod[2*WIDTH-1:WIDTH];
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          w_state_next = S_BUSY;
          w_accept     = 1'b1;
        end
        S_BUSY: if (r_cnt == c_last) begin
          w_state_next = S_DONE;
          w_last       = 1'b1;
        end
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_f3     <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_bzero  <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_f3    <= funct3;
      r_rd    <= rd_in;
      r_a_neg <= w_a_neg;
      r_b_neg <= w_b_neg;
      r_bzero <= (op_b == '0);
      r_acc   <= funct3[2] ? {{WIDTH{1'b0}}, w_a_abs} : {{WIDTH{1'b0}}, w_b_abs};
      r_opnd  <= funct3[2] ? w_b_abs : w_a_abs;
    end else if (r_state == S_BUSY && !flush) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_acc_next;
      if (w_last)
        r_result <= w_final;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd;
  assign we_out = r_done && (r_rd != 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we_out (we_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one operation and checks the exact WIDTH-cycle latency and outputs
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    logic early;
    early = 1'b0;
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op_a = 32'h5A5A_A5A5; op_b = 32'h0F0F_F0F0; funct3 = ~f3;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      early = early | done;
    end
    chk({tag, "_early_done"}, 32'(early), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_rd"}, 32'(rd_out), 32'(rd));
    chk({tag, "_we"}, 32'(we_out), 32'(rd != 5'd0));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", {25'd0, busy, done, we_out, rd_out}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000);
    run_op("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000);
    run_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'hC000_0000);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF);
    run_op("divu",   3'b101, 32'd100,       32'd7,         5'd11, 32'h0000_000E);
    run_op("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'h0000_0002);
    run_op("div_ovf",3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    run_op("rem_ovf",3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000);
    run_op("divu_z", 3'b101, 32'h0000_1234, 32'd0,         5'd15, 32'hFFFF_FFFF);
    run_op("remu_z", 3'b111, 32'h0000_1234, 32'd0,         5'd16, 32'h0000_1234);
    run_op("div_z",  3'b100, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFFF);
    run_op("rem_z",  3'b110, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFF9);

    // start held high through the whole operation with changing operands
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd20;
    seen = 1'b0;
    for (int k = 1; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | done;
    end
    chk("hold_early_done", 32'(seen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_result", result, 32'd12);
    chk("hold_rd", 32'(rd_out), 32'd7);
    start = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | busy | done;
    end
    chk("hold_no_second", 32'(seen), 32'd0);

    // flush at iteration 10
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd9; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("flush_no_done", 32'(seen), 32'd0);
    chk("flush_result_kept", result, 32'd12);

    // flush and start together in IDLE
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd4;
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("flush_start_rd", 32'(rd_out), 32'd9);

    run_op("rd0", 3'b000, 32'd2, 32'd3, 5'd0, 32'd6);

    // asynchronous reset mid-BUSY, between clock edges
    @(negedge clk);
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_rd", 32'(rd_out), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_ctrl", {25'd0, busy, done, we_out, rd_out}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("arst_no_done", 32'(seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
